legv8_mem_arbiter: RTL and testbench

- Sequences a single-port unified memory shared by the IF stage (instruction fetch) and the MEM stage (load/store) of the 5-stage LEGv8 pipeline.
- Grants one requester at a time and runs each access through a fixed-latency transaction.
- Returns read data to the granted requester.
- Drives the pipeline-wide stall while any request is outstanding.

---
 rtl/legv8_mem_pkg.sv | 23 ++
 rtl/legv8_arb_perf.sv | 31 +++
 rtl/legv8_mem_arbiter.sv | 154 +++++++++++++++
 tb/tb_legv8_mem_arbiter.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/legv8_mem_pkg.sv
// Shared types and default widths for the LEGv8 unified-memory arbiter.
package legv8_mem_pkg;

  localparam int unsigned ADDR_W_DEF     = 64;
  localparam int unsigned DATA_W_DEF     = 64;
  localparam int unsigned MEM_LAT_DEF    = 2;
  localparam int unsigned STARVE_MAX_DEF = 4;
  localparam int unsigned INSN_W         = 32;
  localparam int unsigned PERF_W         = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  typedef enum logic {
    OWN_IF  = 1'b0,
    OWN_MEM = 1'b1
  } owner_t;

endpackage

// File: rtl/legv8_arb_perf.sv
// Arbiter performance counters (stall cycles, fetch grants, data grants).
// Present only when ARB_PERF_CNT_EN is defined.
`ifdef ARB_PERF_CNT_EN
module legv8_arb_perf
  import legv8_mem_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              if_grant,
  input  logic              mem_grant,
  output logic [PERF_W-1:0] perf_stall_cyc,
  output logic [PERF_W-1:0] perf_if_grants,
  output logic [PERF_W-1:0] perf_mem_grants
);

  // Free-running counters; wrap naturally at 2^32.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_stall_cyc  <= '0;
      perf_if_grants  <= '0;
      perf_mem_grants <= '0;
    end else begin
      if (stall)     perf_stall_cyc  <= perf_stall_cyc + PERF_W'(1);
      if (if_grant)  perf_if_grants  <= perf_if_grants + PERF_W'(1);
      if (mem_grant) perf_mem_grants <= perf_mem_grants + PERF_W'(1);
    end
  end

endmodule
`endif

// File: rtl/legv8_mem_arbiter.sv
// Single-port memory arbiter between LEGv8 IF and MEM stages with fixed-latency
// transactions. Define ARB_PERF_CNT_EN to add the perf counter outputs.
module legv8_mem_arbiter
  import legv8_mem_pkg::*;
#(
  parameter int unsigned ADDR_W     = ADDR_W_DEF,
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned MEM_LAT    = MEM_LAT_DEF,
  parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [INSN_W-1:0] if_rdata,
  output logic              if_ready,
  input  logic              mem_rd,
  input  logic              mem_wr,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_ready,
  output logic              stall,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
`ifdef ARB_PERF_CNT_EN
  output logic [PERF_W-1:0] perf_stall_cyc,
  output logic [PERF_W-1:0] perf_if_grants,
  output logic [PERF_W-1:0] perf_mem_grants,
`endif
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam int unsigned WCNT_W = (MEM_LAT > 2) ? $clog2(MEM_LAT - 1) : 1;
  localparam int unsigned SCNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [WCNT_W-1:0] WAIT_INIT  = WCNT_W'((MEM_LAT > 1) ? MEM_LAT - 2 : 0);
  localparam logic [SCNT_W-1:0] STARVE_TOP = SCNT_W'(STARVE_MAX);

  arb_state_t        state, state_next;
  logic [WCNT_W-1:0] wait_cnt, wait_next;
  logic [SCNT_W-1:0] starve_cnt;
  owner_t            owner;
  logic              hi_word;
  logic              is_write;
  logic              grant_if, grant_mem;
  logic              data_req;

  assign data_req = mem_rd | mem_wr;
  assign stall    = (if_req & ~if_ready) | (data_req & ~mem_ready);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      wait_cnt <= '0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_next;
    end
  end

  // Arbitration is blocked while a ready pulse is out, so a requester still
  // holding its request in the acknowledge cycle is not granted twice.
  always_comb begin
    state_next = state;
    wait_next  = wait_cnt;
    grant_if   = 1'b0;
    grant_mem  = 1'b0;
    unique case (state)
      IDLE: begin
        if (!(if_ready || mem_ready) && (if_req || data_req)) begin
          state_next = ISSUE;
          if (if_req && (!data_req || starve_cnt == STARVE_TOP)) grant_if  = 1'b1;
          else                                                   grant_mem = 1'b1;
        end
      end
      ISSUE: begin
        if (MEM_LAT == 1) begin
          state_next = RESP;
        end else begin
          state_next = WAIT;
          wait_next  = WAIT_INIT;
        end
      end
      WAIT: begin
        if (wait_cnt == '0) state_next = RESP;
        else                wait_next  = wait_cnt - WCNT_W'(1);
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Grant-time latching, memory strobe and response capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      ram_en     <= 1'b0;
      ram_we     <= 1'b0;
      ram_addr   <= '0;
      ram_wdata  <= '0;
      if_ready   <= 1'b0;
      mem_ready  <= 1'b0;
      if_rdata   <= '0;
      mem_rdata  <= '0;
      owner      <= OWN_IF;
      hi_word    <= 1'b0;
      is_write   <= 1'b0;
      starve_cnt <= '0;
    end else begin
      ram_en    <= grant_if | grant_mem;
      ram_we    <= grant_mem & mem_wr;
      if_ready  <= 1'b0;
      mem_ready <= 1'b0;
      if (grant_if) begin
        ram_addr   <= if_addr;
        owner      <= OWN_IF;
        hi_word    <= if_addr[2];
        is_write   <= 1'b0;
        starve_cnt <= '0;
      end
      if (grant_mem) begin
        ram_addr  <= mem_addr;
        ram_wdata <= mem_wdata;
        owner     <= OWN_MEM;
        is_write  <= mem_wr;
        if (if_req && starve_cnt != STARVE_TOP) starve_cnt <= starve_cnt + SCNT_W'(1);
      end
      if (state == RESP) begin
        if (owner == OWN_IF) begin
          if_ready <= 1'b1;
          if_rdata <= hi_word ? ram_rdata[2*INSN_W-1:INSN_W] : ram_rdata[INSN_W-1:0];
        end else begin
          mem_ready <= 1'b1;
          if (!is_write) mem_rdata <= ram_rdata;
        end
      end
    end
  end

`ifdef ARB_PERF_CNT_EN
  legv8_arb_perf u_perf (
    .clk             (clk),
    .reset           (reset),
    .stall           (stall),
    .if_grant        (grant_if),
    .mem_grant       (grant_mem),
    .perf_stall_cyc  (perf_stall_cyc),
    .perf_if_grants  (perf_if_grants),
    .perf_mem_grants (perf_mem_grants)
  );
`endif

endmodule

// File: tb/tb_legv8_mem_arbiter.sv
// Directed self-checking bench for legv8_mem_arbiter (MEM_LAT=2, STARVE_MAX=4).
module tb_legv8_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req;
  logic [63:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ready;
  logic        mem_rd, mem_wr;
  logic [63:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ready;
  logic        stall;
  logic        ram_en, ram_we;
  logic [63:0] ram_addr, ram_wdata, ram_rdata;
`ifdef ARB_PERF_CNT_EN
  logic [31:0] perf_stall_cyc, perf_if_grants, perf_mem_grants;
`endif

  int checks   = 0;
  int failures = 0;

  logic [63:0] rsp_data;
  logic [1:0]  vpipe = 2'b00;

  always #5 clk = ~clk;

  // Read data is valid only MEM_LAT cycles after a read strobe; otherwise junk.
  always @(posedge clk) vpipe <= {vpipe[0], ram_en & ~ram_we};
  assign ram_rdata = vpipe[1] ? rsp_data : 64'hBAD0_BAD0_BAD0_BAD0;

  legv8_mem_arbiter #(
    .ADDR_W(64), .DATA_W(64), .MEM_LAT(2), .STARVE_MAX(4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_rdata  (if_rdata),
    .if_ready  (if_ready),
    .mem_rd    (mem_rd),
    .mem_wr    (mem_wr),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .stall     (stall),
    .ram_en    (ram_en),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
`ifdef ARB_PERF_CNT_EN
    .perf_stall_cyc  (perf_stall_cyc),
    .perf_if_grants  (perf_if_grants),
    .perf_mem_grants (perf_mem_grants),
`endif
    .ram_rdata (ram_rdata)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  int          got_lat;
  logic [31:0] got_insn;
  logic        seq [10];
  int          n;

  initial begin
    reset = 1'b1; if_req = 1'b0; if_addr = '0;
    mem_rd = 1'b0; mem_wr = 1'b0; mem_addr = '0; mem_wdata = '0;
    rsp_data = '0;

    // Reset values
    repeat (2) next_cycle();
    @(negedge clk);
    check("rst_ram_en",    64'(ram_en),    64'(0));
    check("rst_ram_we",    64'(ram_we),    64'(0));
    check("rst_ram_addr",  ram_addr,       64'(0));
    check("rst_ram_wdata", ram_wdata,      64'(0));
    check("rst_if_ready",  64'(if_ready),  64'(0));
    check("rst_mem_ready", 64'(mem_ready), 64'(0));
    check("rst_if_rdata",  64'(if_rdata),  64'(0));
    check("rst_mem_rdata", mem_rdata,      64'(0));
    check("rst_stall",     64'(stall),     64'(0));
    next_cycle();
    reset = 1'b0;
    next_cycle();

    // Single fetch, upper word
    if_req = 1'b1; if_addr = 64'h4; rsp_data = 64'hAAAA_BBBB_1111_2222;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check("f_ram_en",   64'(ram_en),   64'(c == 1));
      if (c == 1) begin
        check("f_ram_addr", ram_addr,     64'h4);
        check("f_ram_we",   64'(ram_we),  64'(0));
      end
      check("f_if_ready", 64'(if_ready), 64'(c == 4));
      check("f_stall",    64'(stall),    64'(c < 4));
      if (c == 4) check("f_if_rdata", 64'(if_rdata), 64'hAAAABBBB);
      next_cycle();
      if (c == 4) if_req = 1'b0;
    end

    // Simultaneous fetch and load: data first, fetch after
    if_req = 1'b1; if_addr = 64'h8; mem_rd = 1'b1; mem_addr = 64'h100;
    rsp_data = 64'h0123_4567_89AB_CDEF;
    for (int c = 0; c < 11; c++) begin
      @(negedge clk);
      check("s_ram_en", 64'(ram_en), 64'(c == 1 || c == 6));
      if (c == 1) check("s_ram_addr_mem", ram_addr, 64'h100);
      if (c == 6) check("s_ram_addr_if",  ram_addr, 64'h8);
      check("s_mem_ready", 64'(mem_ready), 64'(c == 4));
      check("s_if_ready",  64'(if_ready),  64'(c == 9));
      if (c == 4) check("s_mem_rdata", mem_rdata, 64'h0123_4567_89AB_CDEF);
      if (c == 9) check("s_if_rdata",  64'(if_rdata), 64'h89AB_CDEF);
      check("s_stall", 64'(stall), 64'(c < 9));
      next_cycle();
      if (c == 4) mem_rd = 1'b0;
      if (c == 9) if_req = 1'b0;
    end

    // Starvation: continuous load and fetch -> 4 data grants then 1 fetch
    mem_rd = 1'b1; mem_addr = 64'h300; if_req = 1'b1; if_addr = 64'h10;
    rsp_data = 64'h5555_6666_7777_8888;
    n = 0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (ram_en) begin
        if (n < 10) seq[n] = (ram_addr == 64'h10);
        n++;
      end
      next_cycle();
    end
    mem_rd = 1'b0; if_req = 1'b0;
    check("starve_grants", 64'(n), 64'(10));
    for (int i = 0; i < 10; i++)
      check($sformatf("starve_is_fetch%0d", i), 64'(seq[i]), 64'(i % 5 == 4));
    repeat (6) next_cycle();

    // Store: write strobe and data, load data register untouched
    mem_wr = 1'b1; mem_addr = 64'h200; mem_wdata = 64'hDEAD_BEEF_0000_0001;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check("w_ram_en", 64'(ram_en), 64'(c == 1));
      if (c == 1) begin
        check("w_ram_we",    64'(ram_we), 64'(1));
        check("w_ram_addr",  ram_addr,    64'h200);
        check("w_ram_wdata", ram_wdata,   64'hDEAD_BEEF_0000_0001);
      end
      if (c == 2) check("w_ram_we_off", 64'(ram_we), 64'(0));
      check("w_mem_ready", 64'(mem_ready), 64'(c == 4));
      if (c == 4) check("w_mem_rdata", mem_rdata, 64'h5555_6666_7777_8888);
      check("w_stall", 64'(stall), 64'(c < 4));
      next_cycle();
      if (c == 4) mem_wr = 1'b0;
    end

    // Reset during WAIT aborts the fetch
    if_req = 1'b1; if_addr = 64'h0; rsp_data = 64'hCAFE_CAFE_CAFE_CAFE;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      check("r_ram_en",   64'(ram_en),   64'(c == 1));
      check("r_if_ready", 64'(if_ready), 64'(0));
      if (c >= 3) check("r_stall", 64'(stall), 64'(0));
      next_cycle();
      if (c == 1) begin reset = 1'b1; if_req = 1'b0; end
      if (c == 2) reset = 1'b0;
    end

    // Fresh fetch after the abort, lower word
    if_req = 1'b1; if_addr = 64'h0; rsp_data = 64'hFEED_FACE_1234_5678;
    got_lat = -1; got_insn = '0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (if_ready && got_lat < 0) begin
        got_lat  = c;
        got_insn = if_rdata;
      end
      next_cycle();
      if (got_lat >= 0) if_req = 1'b0;
    end
    if_req = 1'b0;
    check("r2_latency", 64'(got_lat),  64'(4));
    check("r2_if_rdata", 64'(got_insn), 64'h1234_5678);

`ifdef ARB_PERF_CNT_EN
    @(negedge clk);
    check("perf_stall_cyc",  64'(perf_stall_cyc),  64'(4));
    check("perf_if_grants",  64'(perf_if_grants),  64'(1));
    check("perf_mem_grants", 64'(perf_mem_grants), 64'(0));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
